reservoir_readout: RTL and testbench

Downstream readout stage for the 10-neuron LIF ring reservoir. Counts spikes per neuron over a fixed window of enabled cycles. At each window close it computes a trained linear readout, y = bias + Σ count_i·w_i, in Q6.10 fixed point. The result is the reservoir's prediction, compared against the NARMA target (also Q6.10).

---
 rtl/readout_pkg.sv | 34 +++
 rtl/spike_window_counter.sv | 42 ++++
 rtl/reservoir_readout.sv | 100 ++++++++++
 tb/tb_reservoir_readout.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared parameters, FSM state type and output saturation for the reservoir readout stage.
package readout_pkg;

   localparam int unsigned N_NEURONS = 10;
   localparam int unsigned WIN_LEN   = 16;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned W_W       = 16;
   localparam int unsigned ACC_W     = 32;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned Q_FRAC    = 10;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StMac,
      StOut
   } state_e;

   // Clamp a Q.10 accumulator to the signed OUT_W range.
   function automatic logic [OUT_W-1:0] sat_to_out(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] max_v;
      logic signed [ACC_W-1:0] min_v;
      max_v = $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
      min_v = $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
      if (acc > max_v) begin
         sat_to_out = max_v[OUT_W-1:0];
      end else if (acc < min_v) begin
         sat_to_out = min_v[OUT_W-1:0];
      end else begin
         sat_to_out = acc[OUT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/spike_window_counter.sv
// Counts spikes per neuron over WIN_LEN enabled cycles and snapshots the counts at window close.
module spike_window_counter
   import readout_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic [N_NEURONS-1:0]                 spikes,
   output logic                                 win_close,
   output logic [N_NEURONS-1:0][CNT_W-1:0]      snapshot
);

   logic [CNT_W-1:0]                  win_cnt_q;
   logic [N_NEURONS-1:0][CNT_W-1:0]   cnt_q;

   always_comb begin
      win_close = en && (win_cnt_q == CNT_W'(WIN_LEN - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         win_cnt_q <= '0;
         cnt_q     <= '0;
         snapshot  <= '0;
      end else if (en) begin
         if (win_close) begin
            // The closing cycle's spikes land in the snapshot; the next window starts empty.
            win_cnt_q <= '0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
               snapshot[i] <= cnt_q[i] + CNT_W'(spikes[i]);
               cnt_q[i]    <= '0;
            end
         end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(spikes[i]);
            end
         end
      end
   end

endmodule

// File: rtl/reservoir_readout.sv
// Linear readout of the LIF ring reservoir: bias + sum(count_i * w_i) in Q6.10, one MAC per cycle.
module reservoir_readout
   import readout_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [N_NEURONS-1:0]        spikes,
   input  logic                        w_we,
   input  logic [3:0]                  w_addr,
   input  logic signed [W_W-1:0]       w_data,
   output logic signed [OUT_W-1:0]     y_out,
   output logic                        y_valid,
   output logic                        busy,
   output logic                        w_err
);

   localparam logic [3:0]    LastIdx  = 4'(N_NEURONS - 1);
   localparam logic [3:0]    BiasAddr = 4'(N_NEURONS);
   localparam int unsigned   ProdW    = CNT_W + 1 + W_W;

   state_e                           state_q, state_d;
   logic [3:0]                       idx_q;
   logic signed [ACC_W-1:0]          acc_q;
   logic [N_NEURONS-1:0][W_W-1:0]    weights_q;
   logic signed [W_W-1:0]            bias_q;
   logic                             win_close;
   logic [N_NEURONS-1:0][CNT_W-1:0]  snapshot;
   logic signed [ProdW-1:0]          prod;

   spike_window_counter u_counter (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .spikes    (spikes),
      .win_close (win_close),
      .snapshot  (snapshot)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (en) state_d = StAccum;
         StAccum: if (win_close) state_d = StMac;
         StMac:   if (idx_q == LastIdx) state_d = StOut;
         StOut:   state_d = StAccum;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StMac) || (state_q == StOut);
      // Counts are unsigned, so zero-extend before the signed multiply.
      prod = $signed({1'b0, snapshot[idx_q]}) * $signed(weights_q[idx_q]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         acc_q     <= '0;
         weights_q <= '0;
         bias_q    <= '0;
         y_out     <= '0;
         y_valid   <= 1'b0;
         w_err     <= 1'b0;
      end else begin
         state_q <= state_d;
         y_valid <= 1'b0;
         w_err   <= 1'b0;

         if (state_q == StAccum && win_close) begin
            acc_q <= ACC_W'(bias_q);
            idx_q <= '0;
         end

         if (state_q == StMac) begin
            acc_q <= acc_q + ACC_W'(prod);
            idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
         end

         if (state_q == StOut) begin
            y_out   <= sat_to_out(acc_q);
            y_valid <= 1'b1;
         end

         // Weights are frozen while busy so the MAC always sees one consistent set.
         if (w_we) begin
            if (busy) begin
               w_err <= 1'b1;
            end else if (w_addr < BiasAddr) begin
               weights_q[w_addr] <= w_data;
            end else if (w_addr == BiasAddr) begin
               bias_q <= w_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_reservoir_readout.sv
// Directed, scoreboard-based bench for reservoir_readout with an independent readout model.
module tb_reservoir_readout;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [9:0]  spikes;
   logic        w_we;
   logic [3:0]  w_addr;
   logic [15:0] w_data;
   logic [15:0] y_out;
   logic        y_valid;
   logic        busy;
   logic        w_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cycle    = 0;

   logic [15:0] exp_q[$];
   int          close_q[$];

   int          m_w[10];
   int          m_bias;
   int          m_cnt[10];
   int          m_win;

   reservoir_readout dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .spikes  (spikes),
      .w_we    (w_we),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .y_out   (y_out),
      .y_valid (y_valid),
      .busy    (busy),
      .w_err   (w_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] model_y();
      longint s;
      s = longint'(m_bias);
      for (int i = 0; i < 10; i++) s += longint'(m_cnt[i]) * longint'(m_w[i]);
      if (s > 32767) return 16'h7fff;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 10; i++) begin
         m_w[i]   = 0;
         m_cnt[i] = 0;
      end
      m_bias = 0;
      m_win  = 0;
   endfunction

   // Every y_valid pulse must match a pending scoreboard entry, both in value and in timing.
   always @(negedge clk) begin
      if (y_valid === 1'b1) begin
         check("y_valid_expected", 32'(y_valid), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            check("y_out", 32'(y_out), 32'(exp_q.pop_front()));
            check("latency", 32'(cycle), 32'(close_q.pop_front() + 11));
         end
      end
   end

   task automatic step(input logic e, input logic [9:0] s);
      en     = e;
      spikes = s;
      if (e) begin
         for (int i = 0; i < 10; i++) m_cnt[i] += int'(s[i]);
         m_win++;
         if (m_win == 16) begin
            exp_q.push_back(model_y());
            close_q.push_back(cycle + 1);
            m_win = 0;
            for (int i = 0; i < 10; i++) m_cnt[i] = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 10'd0);
   endtask

   task automatic write_w(input logic [3:0] a, input logic [15:0] d, input logic exp_err);
      w_we   = 1'b1;
      w_addr = a;
      w_data = d;
      if (!exp_err) begin
         if (a < 10) m_w[a] = int'($signed(d));
         else if (a == 10) m_bias = int'($signed(d));
      end
      step(1'b0, 10'd0);
      w_we = 1'b0;
      check("w_err", 32'(w_err), 32'(exp_err));
   endtask

   task automatic write_all(input logic [15:0] wv, input logic [15:0] bv);
      for (int a = 0; a < 10; a++) write_w(4'(a), wv, 1'b0);
      write_w(4'd10, bv, 1'b0);
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      w_we = 1'b0;
      for (int i = 0; i < 2; i++) begin
         en     = 1'($urandom_range(0, 1));
         spikes = 10'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      rst    = 1'b1;
      en     = 1'b0;
      spikes = '0;
      model_clear();
      exp_q.delete();
      close_q.delete();
      check("rst_y_out", 32'(y_out), 32'h0);
      check("rst_y_valid", 32'(y_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_w_err", 32'(w_err), 32'h0);
   endtask

   initial begin
      rst    = 1'b0;
      en     = 1'b0;
      spikes = '0;
      w_we   = 1'b0;
      w_addr = '0;
      w_data = '0;
      model_clear();
      @(negedge clk);

      // Reset with random activity on the inputs.
      do_reset();
      idle(3);

      // Unit weight on neuron 0, one spike every cycle.
      write_w(4'd0, 16'h0400, 1'b0);
      for (int c = 0; c < 16; c++) step(1'b1, 10'b1);
      check("busy_mac", 32'(busy), 32'h1);
      idle(14);

      // Negative bias and weight on neuron 3; out-of-range addresses ignored.
      write_w(4'd0, 16'h0000, 1'b0);
      write_w(4'd10, 16'hfc00, 1'b0);
      write_w(4'd3, 16'hfe00, 1'b0);
      write_w(4'd11, 16'h1234, 1'b0);
      write_w(4'd15, 16'h4321, 1'b0);
      for (int c = 0; c < 16; c++) step(1'b1, (c < 2) ? 10'b1000 : 10'b0);
      idle(14);

      // Saturation in both directions.
      write_all(16'h7fff, 16'h0000);
      for (int c = 0; c < 16; c++) step(1'b1, 10'h3ff);
      idle(14);
      write_all(16'h8000, 16'h0000);
      for (int c = 0; c < 16; c++) step(1'b1, 10'h3ff);
      idle(14);

      // 50% enable, back-to-back windows with spikes arriving during the MAC.
      write_all(16'h0000, 16'h0000);
      write_w(4'd0, 16'h0400, 1'b0);
      write_w(4'd1, 16'h0100, 1'b0);
      for (int c = 0; c < 96; c++) begin
         logic [9:0] s;
         s = {8'b0, 1'($urandom_range(0, 1)), 1'b1};
         step((c % 2) == 0, s);
      end
      idle(14);

      // Write while busy is rejected and the weight survives into the next window.
      write_w(4'd1, 16'h0000, 1'b0);
      for (int c = 0; c < 16; c++) step(1'b1, 10'b1);
      write_w(4'd0, 16'h0800, 1'b1);
      step(1'b0, 10'd0);
      check("w_err_pulse", 32'(w_err), 32'h0);
      idle(12);
      for (int c = 0; c < 16; c++) step(1'b1, 10'b1);
      idle(14);

      // Reset in the middle of a MAC drops the pending result.
      for (int c = 0; c < 16; c++) step(1'b1, 10'b11);
      idle(3);
      check("busy_before_rst", 32'(busy), 32'h1);
      do_reset();
      idle(20);

      for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
